mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 9, word address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted before each access; legal range 0..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-low.
REQ-006 read  input  1  read request strobe, sampled on clk rising edge.
REQ-007 write  input  1  write request strobe, sampled on clk rising edge.
REQ-008 addr  input  ADDR_W  word address, from the MAR low bits.
REQ-009 din  input  DATA_W  write data, from the MDR output.
REQ-010 Mdatain  output  DATA_W  registered read data, feeding the MDR memory-side input.
REQ-011 busy  output  1  high while a request is in progress (states WAIT and DONE).
REQ-012 done  output  1  one-cycle completion pulse for both reads and writes.
REQ-013 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and DONE; the state after reset SHALL be IDLE.
REQ-015 IDLE with exactly one of read/write high at edge E0: latch addr, din and op; load the wait counter with WAIT_CYCLES; go to WAIT.
REQ-016 WAIT with counter != 0: decrement the counter; stay in WAIT.
REQ-017 WAIT with counter == 0: perform the access on this edge and go to DONE.
REQ-018 Write access: mem[latched addr] <= latched din. Read access: Mdatain <= mem[latched addr].
REQ-019 DONE: done = 1 for exactly one cycle; on the next edge, go to IDLE unconditionally.
REQ-020 Latency: done is high in the cycle following edge E0 + WAIT_CYCLES + 1; with WAIT_CYCLES = 0, done is high in the cycle after E0 + 1.
REQ-021 Mdatain SHALL change only on a read access or on reset, and SHALL hold its value across writes and idle cycles.
REQ-022 read and write both high in IDLE: no access; state stays IDLE; err pulses for one cycle.
REQ-023 read or write asserted in WAIT or DONE: ignored (not queued, no err); addr/din changes during WAIT have no effect.
REQ-024 Back-to-back requests: the minimum spacing between accepted requests is WAIT_CYCLES + 3 edges, because a new request is accepted only in IDLE.
REQ-025 A read of an address written by any earlier completed write SHALL return that written data.
REQ-026 Every addr value is in range, since DEPTH = 2**ADDR_W; no bounds check is required.
REQ-027 Memory contents are uninitialised at power-up; the bench SHALL write an address before reading it.

Reset
REQ-028 clr low SHALL immediately force: state = IDLE; counter = 0; Mdatain = 0; busy = 0; done = 0; err = 0.
REQ-029 clr asserted during WAIT SHALL abort the request; a pending write SHALL NOT modify the memory.
REQ-030 Memory array contents SHALL be retained through reset and SHALL NOT be cleared.
REQ-031 After clr is released, the first rising edge SHALL accept a request as in REQ-015.

Structure
REQ-032 Shared package mem_pkg SHALL hold the state enum (IDLE/WAIT/DONE) and the DATA_W and ADDR_W default constants.
REQ-033 The storage SHALL be the single sub-module mem_array: single-port, synchronous write, registered read, no reset.
REQ-034 mem_responder SHALL hold the FSM, the wait counter, the request latches and the output registers.

Verification
REQ-035 Write then read (WAIT_CYCLES = 2): write addr 0x010 din 0xDEADBEEF, then read 0x010 -> done 3 cycles after each accepted edge; Mdatain = 0xDEADBEEF; busy high for 4 cycles per request.
REQ-036 Zero wait (WAIT_CYCLES = 0): write 0x1FF din 0x12345678, then read -> done in the cycle after E0 + 1; Mdatain = 0x12345678.
REQ-037 Conflict: read = write = 1 in IDLE -> err pulses for 1 cycle; busy, done and memory unchanged; Mdatain keeps its prior value.
REQ-038 Ignored request: second write to 0x020 asserted during WAIT -> no extra done pulse; mem[0x020] unchanged.
REQ-039 Reset mid-write: write 0x030 din 0xAAAA5555 with clr pulsed low in WAIT -> outputs 0 at once; a later read of 0x030 returns its pre-write value.
REQ-040 Hold: read 0x010 = 0xDEADBEEF, then write 0x011 din 0x0 -> Mdatain stays 0xDEADBEEF throughout.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default sizes for the memory responder and its storage array.
package mem_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 9;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read, contents never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one read or write in IDLE, counts wait
// states, performs the access, then pulses done.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] Mdatain,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    op_t               op_q;
    logic              accept;
    logic              conflict;
    logic              access;

    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_we;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        conflict = 1'b0;
        access   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (read ^ write) begin
                    accept   = 1'b1;
                    cnt_nx   = WAIT_LD;
                    state_nx = WAIT;
                end else if (read && write) begin
                    conflict = 1'b1;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    access   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            addr_q <= '0;
            din_q  <= '0;
            op_q   <= OP_READ;
        end else if (accept) begin
            addr_q <= addr;
            din_q  <= din;
            op_q   <= write ? OP_WRITE : OP_READ;
        end
    end

    // The array's registered read runs one edge ahead of the access: in IDLE it
    // looks at the live address, afterwards at the latched one, so its output
    // already holds mem[addr_q] on the access edge (even with zero wait states).
    assign arr_addr = (state == IDLE) ? addr : addr_q;
    assign arr_we   = access && (op_q == OP_WRITE);

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (din_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Mdatain <= '0;
            err     <= 1'b0;
        end else begin
            if (access && (op_q == OP_READ)) begin
                Mdatain <= arr_rdata;
            end
            err <= conflict;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against an array model.
module tb_mem_responder;

    logic        clk;
    logic        clr;
    logic        rd  [2];
    logic        wr  [2];
    logic [8:0]  ad  [2];
    logic [31:0] dn  [2];
    logic [31:0] mdo [2];
    logic        bsy [2];
    logic        dne [2];
    logic        er  [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [2][512];
    bit          vld   [2][512];
    logic [31:0] mq    [2];

    mem_responder #(
        .DATA_W      (32),
        .ADDR_W      (9),
        .WAIT_CYCLES (2)
    ) u_w2 (
        .clk     (clk),
        .clr     (clr),
        .read    (rd[0]),
        .write   (wr[0]),
        .addr    (ad[0]),
        .din     (dn[0]),
        .Mdatain (mdo[0]),
        .busy    (bsy[0]),
        .done    (dne[0]),
        .err     (er[0])
    );

    mem_responder #(
        .DATA_W      (32),
        .ADDR_W      (9),
        .WAIT_CYCLES (0)
    ) u_w0 (
        .clk     (clk),
        .clr     (clr),
        .read    (rd[1]),
        .write   (wr[1]),
        .addr    (ad[1]),
        .din     (dn[1]),
        .Mdatain (mdo[1]),
        .busy    (bsy[1]),
        .done    (dne[1]),
        .err     (er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outs(input int d, input string tag);
        chk({tag, "_busy"}, 32'(bsy[d]), 32'd0);
        chk({tag, "_done"}, 32'(dne[d]), 32'd0);
        chk({tag, "_err"},  32'(er[d]),  32'd0);
        chk({tag, "_mdat"}, mdo[d], mq[d]);
    endtask

    // One accepted request; inj drives a write to 0x020 (and junk address/data)
    // during the first wait cycle, which must be ignored entirely.
    task automatic req(input int d, input bit w, input logic [8:0] a,
                       input logic [31:0] v, input bit inj);
        int unsigned wc;
        logic [31:0] exp_m;
        wc    = (d == 0) ? 2 : 0;
        exp_m = w ? mq[d] : mem_m[d][a];
        @(negedge clk);
        rd[d] = !w; wr[d] = w; ad[d] = a; dn[d] = v;
        @(posedge clk); #1;
        chk("acc_busy", 32'(bsy[d]), 32'd1);
        chk("acc_done", 32'(dne[d]), 32'd0);
        @(negedge clk);
        if (inj) begin
            rd[d] = 1'b0; wr[d] = 1'b1; ad[d] = 9'h020; dn[d] = $urandom;
        end else begin
            rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 9'($urandom); dn[d] = $urandom;
        end
        for (int unsigned c = 1; c <= wc + 2; c++) begin
            @(posedge clk); #1;
            chk("req_err", 32'(er[d]), 32'd0);
            if (c <= wc) begin
                chk("wait_done", 32'(dne[d]), 32'd0);
                chk("wait_busy", 32'(bsy[d]), 32'd1);
                chk("wait_mdat", mdo[d], mq[d]);
            end else if (c == wc + 1) begin
                chk("done_pulse", 32'(dne[d]), 32'd1);
                chk("done_busy",  32'(bsy[d]), 32'd1);
                chk("done_mdat",  mdo[d], exp_m);
            end else begin
                chk("end_done", 32'(dne[d]), 32'd0);
                chk("end_busy", 32'(bsy[d]), 32'd0);
                chk("end_mdat", mdo[d], exp_m);
            end
            if (c == 1) begin
                @(negedge clk);
                rd[d] = 1'b0; wr[d] = 1'b0;
            end
        end
        if (w) begin
            mem_m[d][a] = v;
            vld[d][a]   = 1'b1;
        end
        mq[d] = exp_m;
    endtask

    task automatic conflict(input int d, input logic [8:0] a);
        @(negedge clk);
        rd[d] = 1'b1; wr[d] = 1'b1; ad[d] = a; dn[d] = $urandom;
        @(posedge clk); #1;
        chk("cf_err",  32'(er[d]),  32'd1);
        chk("cf_busy", 32'(bsy[d]), 32'd0);
        chk("cf_done", 32'(dne[d]), 32'd0);
        chk("cf_mdat", mdo[d], mq[d]);
        @(negedge clk);
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
        chk_idle_outs(d, "cf_after");
    endtask

    initial begin
        logic [8:0] ra;
        bit         rw;
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; dn[i] = '0; mq[i] = '0;
            for (int j = 0; j < 512; j++) vld[i][j] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outs(0, "rst0");
        chk_idle_outs(1, "rst1");
        clr = 1'b1;

        // Two-wait-state responder: directed scenarios.
        req(0, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0);
        req(0, 1'b0, 9'h010, 32'h0, 1'b0);
        req(0, 1'b1, 9'h011, 32'h00000000, 1'b0);
        req(0, 1'b1, 9'h020, 32'h11112222, 1'b0);
        req(0, 1'b1, 9'h040, 32'hCAFEF00D, 1'b1);
        req(0, 1'b0, 9'h020, 32'h0, 1'b0);
        conflict(0, 9'h020);
        req(0, 1'b0, 9'h020, 32'h0, 1'b0);
        req(0, 1'b0, 9'h040, 32'h0, 1'b0);

        // Abort a write with reset while it waits.
        req(0, 1'b1, 9'h030, 32'h0F0F1234, 1'b0);
        @(negedge clk);
        wr[0] = 1'b1; ad[0] = 9'h030; dn[0] = 32'hAAAA5555;
        @(posedge clk); #1;
        chk("abort_acc", 32'(bsy[0]), 32'd1);
        @(negedge clk);
        wr[0] = 1'b0;
        #1 clr = 1'b0;
        #1;
        mq[0] = '0; mq[1] = '0;
        chk_idle_outs(0, "abort0");
        chk_idle_outs(1, "abort1");
        @(posedge clk); #1;
        chk_idle_outs(0, "abort_hold");
        clr = 1'b1;
        req(0, 1'b0, 9'h030, 32'h0, 1'b0);

        // Zero-wait-state responder.
        req(1, 1'b1, 9'h1FF, 32'h12345678, 1'b0);
        req(1, 1'b0, 9'h1FF, 32'h0, 1'b0);
        req(1, 1'b1, 9'h020, 32'h55667788, 1'b0);
        req(1, 1'b1, 9'h000, 32'h9ABCDEF0, 1'b1);
        req(1, 1'b0, 9'h020, 32'h0, 1'b0);
        conflict(1, 9'h1FF);
        req(1, 1'b0, 9'h1FF, 32'h0, 1'b0);

        // Random traffic over a small address pool so reads hit earlier writes.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                ra = 9'h100 + 9'($urandom_range(0, 7));
                rw = (n == 0) || !vld[d][ra] || ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 9) == 0) begin
                    conflict(d, ra);
                end else begin
                    req(d, rw, ra, $urandom, $urandom_range(0, 3) == 0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
